// File: rtl/sent_rx_pulse_decode.sv
// SENT receiver pulse decoder: measures falling-edge to falling-edge periods and decodes sync, status, data and CRC nibbles.
// Optional CRC check is built when SENT_RX_CRC_CHECK_EN is defined; otherwise crc_err is tied low.
module sent_rx_pulse_decode (
  input  logic        ticks,
  input  logic        reset,
  input  logic        data_pulse,
  output logic [3:0]  nibble,
  output logic [2:0]  nibble_idx,
  output logic        nibble_valid,
  output logic [3:0]  status,
  output logic [23:0] frame_data,
  output logic        frame_valid,
  output logic        crc_err,
  output logic        pulse_err,
  output logic        sync_lost
);
  typedef enum logic [1:0] {HUNT, SYNC, DATA, TAIL} state_t;

  localparam logic [9:0] SAT_P  = 10'd1023;
  localparam logic [9:0] SYNC_P = 10'd56;

  state_t      r_state;
  logic        r_prev;
  logic [9:0]  r_period_cnt;
  logic [2:0]  r_low_cnt;
  logic [2:0]  r_idx;
  logic [3:0]  r_stat_acc;
  logic [23:0] r_data_acc;

  logic       w_fall;
  logic       w_rise;
  logic       w_sat;
  logic       w_nib_ok;
  logic       w_dec;
  logic [3:0] w_nib;

  assign w_fall   = r_prev & ~data_pulse;
  assign w_rise   = ~r_prev & data_pulse;
  assign w_sat    = (r_period_cnt == SAT_P);
  assign w_nib_ok = (r_period_cnt >= 10'd12) && (r_period_cnt <= 10'd27);
  assign w_nib    = 4'(r_period_cnt - 10'd12);
  // A nibble is actually decoded only when saturation does not pre-empt the edge.
  assign w_dec    = w_fall && (r_state == DATA) && w_nib_ok && !w_sat;

  always_ff @(posedge ticks) begin
    if (!reset) begin
      r_state      <= HUNT;
      r_prev       <= 1'b1;
      r_period_cnt <= '0;
      r_low_cnt    <= '0;
      r_idx        <= '0;
      r_stat_acc   <= '0;
      r_data_acc   <= '0;
      nibble       <= '0;
      nibble_idx   <= '0;
      nibble_valid <= 1'b0;
      status       <= '0;
      frame_data   <= '0;
      frame_valid  <= 1'b0;
      pulse_err    <= 1'b0;
      sync_lost    <= 1'b0;
    end else begin
      r_prev       <= data_pulse;
      nibble_valid <= 1'b0;
      frame_valid  <= 1'b0;
      pulse_err    <= 1'b0;
      sync_lost    <= 1'b0;

      if (w_fall)      r_period_cnt <= 10'd1;
      else if (!w_sat) r_period_cnt <= r_period_cnt + 10'd1;

      if (data_pulse)               r_low_cnt <= '0;
      else if (r_low_cnt != 3'd7)   r_low_cnt <= r_low_cnt + 3'd1;

      if ((r_state != HUNT) && w_sat) begin
        sync_lost <= 1'b1;
        r_state   <= HUNT;
      end else if ((r_state != HUNT) && w_rise && (r_low_cnt < 3'd4)) begin
        pulse_err <= 1'b1;
        r_state   <= SYNC;
      end else if (w_fall) begin
        case (r_state)
          HUNT: r_state <= SYNC;
          SYNC: begin
            if (r_period_cnt == SYNC_P) begin
              r_state <= DATA;
              r_idx   <= '0;
            end
          end
          DATA: begin
            if (w_nib_ok) begin
              nibble       <= w_nib;
              nibble_idx   <= r_idx;
              nibble_valid <= 1'b1;
              if (r_idx == 3'd0)      r_stat_acc <= w_nib;
              else if (r_idx != 3'd7) r_data_acc <= {r_data_acc[19:0], w_nib};
              if (r_idx == 3'd7) begin
                status      <= r_stat_acc;
                frame_data  <= r_data_acc;
                frame_valid <= 1'b1;
                r_state     <= TAIL;
                r_idx       <= '0;
              end else begin
                r_idx <= r_idx + 3'd1;
              end
            end else begin
              pulse_err <= 1'b1;
              r_state   <= SYNC;
            end
          end
          TAIL: begin
            r_idx   <= '0;
            r_state <= (r_period_cnt == SYNC_P) ? DATA : SYNC;
          end
          default: r_state <= HUNT;
        endcase
      end
    end
  end

`ifdef SENT_RX_CRC_CHECK_EN
  logic [3:0] r_crc;

  // Multiply by x^4 modulo x^4+x^3+x^2+1.
  function automatic logic [3:0] crc_mul4(input logic [3:0] c);
    logic [3:0] v;
    v = c;
    for (int i = 0; i < 4; i++) v = v[3] ? ({v[2:0], 1'b0} ^ 4'hD) : {v[2:0], 1'b0};
    return v;
  endfunction

  always_ff @(posedge ticks) begin
    if (!reset) begin
      r_crc   <= 4'h5;
      crc_err <= 1'b0;
    end else begin
      crc_err <= w_dec && (r_idx == 3'd7) && (crc_mul4(r_crc) != w_nib);
      if (w_dec) begin
        if (r_idx == 3'd0)      r_crc <= 4'h5;
        else if (r_idx != 3'd7) r_crc <= crc_mul4(r_crc) ^ w_nib;
      end
    end
  end
`else
  assign crc_err = 1'b0;
`endif

endmodule

// File: tb/tb_sent_rx_pulse_decode.sv
// Bench for sent_rx_pulse_decode: table vectors, directed frame sequences and random pulse trains
// checked against a frame-level reference model.
module tb_sent_rx_pulse_decode;
  logic        ticks = 1'b0;
  logic        reset;
  logic        data_pulse;
  logic [3:0]  nibble;
  logic [2:0]  nibble_idx;
  logic        nibble_valid;
  logic [3:0]  status;
  logic [23:0] frame_data;
  logic        frame_valid;
  logic        crc_err;
  logic        pulse_err;
  logic        sync_lost;

  sent_rx_pulse_decode dut (
    .ticks(ticks), .reset(reset), .data_pulse(data_pulse),
    .nibble(nibble), .nibble_idx(nibble_idx), .nibble_valid(nibble_valid),
    .status(status), .frame_data(frame_data), .frame_valid(frame_valid),
    .crc_err(crc_err), .pulse_err(pulse_err), .sync_lost(sync_lost)
  );

  always #5 ticks = ~ticks;

`ifdef SENT_RX_CRC_CHECK_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  // Event word layout: {nv, nib[3:0], idx[2:0], fv, ce, pe, sl, status[3:0], frame_data[23:0]}
  localparam int B_NV = 39;
  localparam int B_FV = 31;
  localparam int B_CE = 30;
  localparam int B_PE = 29;
  localparam int B_SL = 28;

  typedef struct { int per; int low; } pulse_t;
  typedef struct { int cyc; logic [39:0] v; } ev_t;
  typedef struct { int per; int low; int nv; int nib; int pe; } vec_t;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  pulse_t      seq[$];
  ev_t         obs[$];
  logic [39:0] expq[$];
  int          falls[$];
  int          crc_tbl[16] = '{0, 13, 7, 10, 14, 3, 9, 4, 1, 12, 6, 11, 15, 2, 8, 5};

  always @(posedge ticks) cyc <= cyc + 1;

  always @(negedge ticks) begin
    if (nibble_valid || frame_valid || crc_err || pulse_err || sync_lost)
      obs.push_back('{cyc, {nibble_valid, nibble, nibble_idx, frame_valid, crc_err,
                            pulse_err, sync_lost, status, frame_data}});
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [39:0] mk(input bit nv, input int nib, input int idx, input bit fv,
                                     input bit ce, input bit pe, input bit sl, input int st, input int fd);
    return {nv, 4'(nib), 3'(idx), fv, ce, pe, sl, 4'(st), 24'(fd)};
  endfunction

  function automatic int crc_calc(input logic [23:0] d);
    int c;
    c = 5;
    for (int k = 0; k < 6; k++) c = crc_tbl[c] ^ int'(d[(5 - k) * 4 +: 4]);
    return crc_tbl[c];
  endfunction

  function automatic int cnt(input int b);
    int n;
    n = 0;
    foreach (obs[i]) if (obs[i].v[b]) n++;
    return n;
  endfunction

  // Reference: walk the sent pulse list edge by edge and list the strobes each edge should produce.
  task automatic build_model();
    int mode, pos, lnib, lidx, st, fd, p, c;
    int nb[8];
    bit ce;
    mode = 0; pos = 0; lnib = 0; lidx = 0; st = 0; fd = 0; p = 0;
    expq.delete();
    for (int i = 0; i < seq.size(); i++) begin
      if (i > 0) begin
        p = seq[i-1].per;
        if (p >= 1023 && mode != 0) begin
          expq.push_back(mk(0, lnib, lidx, 0, 0, 0, 1, st, fd));
          mode = 0;
        end
      end
      if (mode == 0) mode = 1;
      else if (mode == 1) begin
        if (p == 56) begin mode = 2; pos = 0; end
      end else if (mode == 2) begin
        if (p >= 12 && p <= 27) begin
          nb[pos] = p - 12; lnib = nb[pos]; lidx = pos;
          if (pos == 7) begin
            st = nb[0];
            fd = 0;
            for (int k = 1; k <= 6; k++) fd = fd * 16 + nb[k];
            c  = crc_calc(24'(fd));
            ce = CRC_EN && (c != nb[7]);
            expq.push_back(mk(1, lnib, lidx, 1, ce, 0, 0, st, fd));
            mode = 3;
          end else begin
            expq.push_back(mk(1, lnib, lidx, 0, 0, 0, 0, st, fd));
            pos++;
          end
        end else begin
          expq.push_back(mk(0, lnib, lidx, 0, 0, 1, 0, st, fd));
          mode = 1;
        end
      end else begin
        mode = (p == 56) ? 2 : 1;
        pos = 0;
      end
      if (seq[i].low < 4 && mode != 0) begin
        expq.push_back(mk(0, lnib, lidx, 0, 0, 1, 0, st, fd));
        mode = 1;
      end
    end
  endtask

  task automatic tx(input int per, input int low);
    seq.push_back('{per, low});
    data_pulse = 1'b0;
    falls.push_back(cyc + 1);
    repeat (low) @(posedge ticks);
    #1;
    data_pulse = 1'b1;
    repeat (per - low) @(posedge ticks);
    #1;
  endtask

  task automatic tx_frame(input int st, input logic [23:0] d, input int crc_delta, input int pause);
    tx(56, 5);
    tx(12 + st, 5);
    for (int k = 0; k < 6; k++) tx(12 + int'(d[(5 - k) * 4 +: 4]), 5);
    tx(12 + ((crc_calc(d) + crc_delta) & 15), 5);
    if (pause > 0) tx(pause, 5);
  endtask

  task automatic begin_scn();
    reset = 1'b0;
    data_pulse = 1'b1;
    repeat (3) @(posedge ticks);
    #1;
    reset = 1'b1;
    repeat (5) @(posedge ticks);
    #1;
    obs.delete(); seq.delete(); falls.delete();
  endtask

  task automatic end_scn(input string name);
    repeat (20) @(posedge ticks);
    #1;
    build_model();
    chk({name, " event count"}, obs.size(), expq.size());
    for (int i = 0; i < expq.size() && i < obs.size(); i++)
      chk($sformatf("%s event %0d", name, i), obs[i].v, expq[i]);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[7];
    int k, per, low, r;
    vt[0] = '{12, 5, 1, 0,  0};
    vt[1] = '{27, 5, 1, 15, 0};
    vt[2] = '{11, 5, 0, 0,  1};
    vt[3] = '{28, 5, 0, 0,  1};
    vt[4] = '{19, 4, 1, 7,  0};
    vt[5] = '{15, 3, 0, 0,  1};
    vt[6] = '{56, 5, 0, 0,  1};

    reset = 1'b0;
    data_pulse = 1'b1;
    repeat (2) @(posedge ticks);
    @(negedge ticks);
    chk("reset outputs", {nibble, nibble_idx, nibble_valid, status, frame_data,
                          frame_valid, crc_err, pulse_err, sync_lost}, 64'h0);
    @(posedge ticks);
    #1;

    begin_scn();
    tx_frame(3, 24'h123456, 0, 80);
    end_scn("basic");
    chk("basic nibble strobes", cnt(B_NV), 8);
    chk("basic frame strobes", cnt(B_FV), 1);
    k = 0;
    foreach (obs[i]) if (obs[i].v[B_NV]) begin
      chk($sformatf("basic idx %0d", k), obs[i].v[34:32], k);
      chk($sformatf("basic latency %0d", k), obs[i].cyc, (k + 2 < falls.size()) ? falls[k + 2] : -1);
      k++;
    end
    foreach (obs[i]) if (obs[i].v[B_FV]) chk("basic crc_err", obs[i].v[B_CE], 0);
    chk("basic status/data", {status, frame_data}, {4'h3, 24'h123456});

    begin_scn();
    tx_frame(3, 24'h123456, 1, 80);
    end_scn("crc");
    chk("crc frame strobes", cnt(B_FV), 1);
    chk("crc crc_err strobes", cnt(B_CE), CRC_EN ? 1 : 0);

    begin_scn();
    tx_frame(3, 24'hABCDEF, 0, 0);
    tx_frame(9, 24'h0F0F0F, 0, 90);
    end_scn("b2b");
    chk("b2b frame strobes", cnt(B_FV), 2);
    chk("b2b status/data", {status, frame_data}, {4'h9, 24'h0F0F0F});

    begin_scn();
    tx_frame(5, 24'h654321, 0, 80);
    tx(56, 5); tx(13, 5); tx(14, 5); tx(15, 5); tx(28, 5);
    tx_frame(7, 24'h13579B, 0, 80);
    end_scn("bad28");
    chk("bad28 pulse_err strobes", cnt(B_PE), 1);
    chk("bad28 frame strobes", cnt(B_FV), 2);
    foreach (obs[i]) if (obs[i].v[B_PE]) chk("bad28 held data", obs[i].v[27:0], {4'h5, 24'h654321});
    chk("bad28 status/data", {status, frame_data}, {4'h7, 24'h13579B});

    begin_scn();
    tx(56, 5);
    tx(1100, 5);
    tx_frame(2, 24'h24680A, 0, 80);
    end_scn("sat");
    chk("sat sync_lost strobes", cnt(B_SL), 1);
    chk("sat first event", (obs.size() > 0) ? obs[0].v[B_SL] : 1'b0, 1);
    chk("sat resume cycle", (obs.size() > 1) ? obs[1].cyc : -1, falls[4]);
    chk("sat frame strobes", cnt(B_FV), 1);

    for (int i = 0; i < 7; i++) begin
      begin_scn();
      tx(56, 5);
      tx(vt[i].per, vt[i].low);
      tx(20, 5);
      end_scn($sformatf("vec%0d", i));
      chk($sformatf("vec%0d nibble strobes", i), cnt(B_NV), vt[i].nv);
      chk($sformatf("vec%0d pulse_err strobes", i), cnt(B_PE), vt[i].pe);
      if (vt[i].nv != 0) chk($sformatf("vec%0d nibble", i), nibble, vt[i].nib);
    end

    begin_scn();
    tx_frame(3, 24'h123456, 0, 80);
    tx(56, 5); tx(15, 5); tx(13, 5); tx(14, 5);
    reset = 1'b0;
    obs.delete();
    @(posedge ticks);
    @(negedge ticks);
    chk("midreset outputs", {nibble, nibble_idx, nibble_valid, status, frame_data,
                             frame_valid, crc_err, pulse_err, sync_lost}, 64'h0);
    @(posedge ticks);
    #1;
    reset = 1'b1;
    tx(15, 5); tx(16, 5);
    repeat (30) @(posedge ticks);
    #1;
    chk("midreset no strobes", obs.size(), 0);

    for (int it = 0; it < 4; it++) begin
      begin_scn();
      for (int j = 0; j < 10; j++) begin
        r = $urandom_range(0, 9);
        if (r < 6) begin
          tx_frame($urandom_range(0, 15), 24'($urandom), ($urandom_range(0, 3) == 0) ? 1 : 0,
                   ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(12, 200));
        end else if (r < 9) begin
          per = $urandom_range(5, 100);
          low = $urandom_range(4, (per - 1 < 6) ? per - 1 : 6);
          tx(per, low);
        end else begin
          tx($urandom_range(10, 60), $urandom_range(2, 3));
        end
      end
      end_scn($sformatf("rand%0d", it));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sent_rx_pulse_decode.md
SENT_RX_PULSE_DECODE -- requirements
Module: sent_rx_pulse_decode

Interface
REQ-001 ticks  input  1  SENT tick clock; one clock period is one SENT unit time; all logic on posedge ticks.
REQ-002 reset  input  1  synchronous active-low reset; sampled on posedge ticks; 0 = reset.
REQ-003 data_pulse  input  1  SENT line, already in the ticks domain; idle high.
REQ-004 nibble  output  4  last decoded nibble value.
REQ-005 nibble_idx  output  3  position of the last nibble: 0 = status, 1-6 = data, 7 = CRC.
REQ-006 nibble_valid  output  1  one-cycle strobe; nibble and nibble_idx are valid.
REQ-007 status  output  4  status nibble of the last complete frame.
REQ-008 frame_data  output  24  data nibbles 1-6 of the last complete frame; nibble 1 in [23:20].
REQ-009 frame_valid  output  1  one-cycle strobe; status and frame_data updated.
REQ-010 crc_err  output  1  one-cycle strobe with frame_valid; CRC mismatch.
REQ-011 pulse_err  output  1  one-cycle strobe; an illegal period or a short low phase was detected.
REQ-012 sync_lost  output  1  one-cycle strobe; the period counter saturated outside HUNT.

Function
REQ-013 prev holds the previous data_pulse sample; a falling edge is a cycle with prev=1 and data_pulse=0.
REQ-014 period_cnt is 10 bits wide.
  - Loads 1 on each falling edge; otherwise increments by 1.
  - Saturates at 1023.
  - Period p is the value of period_cnt sampled on a falling edge, before the reload.
REQ-015 low_cnt counts consecutive low samples.
  - On a rising edge (prev=0, data_pulse=1), low_cnt < 4 in SYNC/DATA/TAIL raises pulse_err and returns the block to SYNC.
REQ-016 States are HUNT, SYNC, DATA and TAIL; reset enters HUNT.
REQ-017 HUNT: on a falling edge, go to SYNC.
REQ-018 SYNC: on a falling edge, p=56 goes to DATA with idx=0; any other p stays in SYNC, and that edge starts a new candidate period.
REQ-019 DATA: on a falling edge with 12<=p<=27, emit nibble=p-12 with nibble_idx=idx and nibble_valid, then increment idx.
REQ-020 DATA at idx=7: emit the CRC nibble, update status/frame_data, pulse frame_valid (and crc_err if applicable), then go to TAIL.
REQ-021 DATA with any other p: raise pulse_err, discard the partial frame (status/frame_data keep their old values), and go to SYNC.
REQ-022 TAIL: on a falling edge, p=56 means the frame had no pause; go to DATA with idx=0. Any other p (12..1022) is accepted as a pause; go to SYNC.
REQ-023 Saturation (period_cnt=1023) in SYNC, DATA or TAIL pulses sync_lost once and returns the block to HUNT; period_cnt stays saturated until the next falling edge.
REQ-024 Latency: every output strobe is registered and is high for exactly the single cycle following the ticks edge that sampled the falling edge.
REQ-025 Strobes never assert in HUNT; when pulse_err and sync_lost would coincide, sync_lost takes priority.
REQ-026 A nibble at 12 ticks decodes to 0x0 and a nibble at 27 ticks decodes to 0xF; 11 or 28 ticks raises pulse_err.

Reset
REQ-027 While reset=0, all of the following take value 0: every output, period_cnt, low_cnt and idx.
REQ-028 While reset=0, prev=1 and the state is HUNT.
REQ-029 Reset asserted mid-frame discards the frame and produces no strobes.
REQ-030 The first falling edge after reset release only starts a measurement; it produces no nibble.

Configuration
REQ-031 SENT_RX_CRC_CHECK_EN defined: compute the CRC over data nibbles 1-6 and compare it with the received CRC nibble.
  - Polynomial x^4+x^3+x^2+1, seed 0x5.
  - Data nibbles are processed in order, followed by one 0x0 nibble (SAE J2716 recommended method).
  - A mismatch pulses crc_err together with frame_valid.
REQ-032 SENT_RX_CRC_CHECK_EN undefined: no CRC logic is built; crc_err is tied to 0; frame_valid behaviour is unchanged.

Verification
REQ-033 Reset, idle high, then sync 56 + nibbles 0x3,0x1,0x2,0x3,0x4,0x5,0x6 + correct CRC + pause.
  - Required: 8 nibble_valid strobes, idx 0-7.
  - Required: frame_valid with status=0x3 and frame_data=0x123456; crc_err=0.
REQ-034 Same frame with the CRC nibble incremented by 1.
  - With the macro: frame_valid=1 and crc_err=1.
  - Without the macro: crc_err=0.
REQ-035 Back-to-back frames with no pause (CRC then sync 56).
  - Required: both frames decode; two frame_valid strobes.
REQ-036 Data nibble with period 28 at idx=3.
  - Required: pulse_err once; no frame_valid; status/frame_data unchanged.
  - Required: a following valid sync+frame decodes correctly.
REQ-037 Line held high for 1100 ticks after a sync.
  - Required: sync_lost exactly once; state HUNT; no strobes until two further falling edges spaced 56 apart.
REQ-038 Periods 12 and 27 decode to 0x0 and 0xF.
  - Required: a 3-tick low phase raises pulse_err.
  - Required: reset asserted mid-frame clears all outputs, and no strobe follows.
